mult_seq: RTL and testbench

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_if.sv | 28 ++
 rtl/mult_seq.sv | 109 ++++++++++
 tb/tb_mult_seq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_if.sv
// Operand/product handshake bundle for mult_seq.
// The optional two's-complement select tc exists only when MULT_SIGNED_EN is defined.
interface mult_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
`ifdef MULT_SIGNED_EN
  logic               tc;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;

`ifdef MULT_SIGNED_EN
  modport master (output in_valid, x, y, tc, out_ready,
                  input  in_ready, out_valid, p);
  modport slave  (input  in_valid, x, y, tc, out_ready,
                  output in_ready, out_valid, p);
`else
  modport master (output in_valid, x, y, out_ready,
                  input  in_ready, out_valid, p);
  modport slave  (input  in_valid, x, y, out_ready,
                  output in_ready, out_valid, p);
`endif
endinterface

// File: rtl/mult_seq.sv
// Sequential shift-and-add multiplier retiring STEP multiplier bits per cycle.
// FSM IDLE -> CALC -> DONE. The product is registered and held until taken.
// Optional macro MULT_SIGNED_EN adds the tc port. With tc=1 the operands are
// two's complement: magnitudes are formed at capture and the unsigned
// magnitude product is negated on DONE entry when the operand signs differ.
module mult_seq #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input logic  clk,
  input logic  rst,
  mult_if.slave bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;   // multiplicand, pre-shifted to the current digit weight
  logic [WIDTH-1:0] mplier; // multiplier, consumed STEP bits at a time from the LSB
  logic [CW-1:0]   cnt;
  logic            out_valid_r;
  logic [PW-1:0]   p_r;

  logic [WIDTH-1:0] mag_x;
  logic [WIDTH-1:0] mag_y;
  logic [PW-1:0]    digit;
  logic [PW-1:0]    term;
  logic [PW-1:0]    result;

`ifdef MULT_SIGNED_EN
  logic neg;
  logic x_neg;
  logic y_neg;

  // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
  assign x_neg  = bus.tc & bus.x[WIDTH-1];
  assign y_neg  = bus.tc & bus.y[WIDTH-1];
  assign mag_x  = x_neg ? -bus.x : bus.x;
  assign mag_y  = y_neg ? -bus.y : bus.y;
  assign result = neg ? -acc : acc;
`else
  assign mag_x  = bus.x;
  assign mag_y  = bus.y;
  assign result = acc;
`endif

  assign digit = PW'(mplier[STEP-1:0]);
  assign term  = mcand * digit;

  // in_ready is decoded from state and forced low while reset is asserted.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.p         = p_r;

  // FSM, datapath and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see pre-edge values.
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      p_r         <= '0;
`ifdef MULT_SIGNED_EN
      neg         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= PW'(mag_x);
            mplier <= mag_y;
            acc    <= '0;
            cnt    <= '0;
`ifdef MULT_SIGNED_EN
            neg    <= x_neg ^ y_neg;
`endif
            state  <= CALC;
          end
        end
        CALC: begin
          if (cnt == CW'(N)) begin
            p_r         <= result;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            acc    <= acc + term;
            mcand  <= mcand << STEP;
            mplier <= mplier >> STEP;
            cnt    <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: a scoreboard queue is filled at operand
// acceptance from an arithmetic reference model, and a forked monitor pops
// and compares whenever the DUT raises out_valid. Define MULT_SIGNED_EN to
// also exercise two's-complement mode.
module tb_mult_seq;
  localparam int WIDTH = 16;
  localparam int STEP  = 1;
  localparam int N     = WIDTH / STEP;
  localparam int PW    = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_if #(.WIDTH(WIDTH)) bus  ();
  mult_if #(.WIDTH(WIDTH)) bus4 ();

  mult_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mult_seq #(.WIDTH(WIDTH), .STEP(4))    dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic [PW-1:0] p;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rand_ready = 1'b0;

  // Count rising edges so latency can be measured in edges.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer product, sign-extending operands when t=1.
  function automatic logic [PW-1:0] model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic t);
    longint sa;
    longint sb;
    if (t) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    return PW'(sa * sb);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one operand pair, push its expectation on acceptance, then drive
  // random junk on in_valid/x/y/tc for 'garbage' cycles while busy.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic t, input int garbage);
    int w = 0;
    while (!bus.in_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", bus.in_ready, 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.x        = a;
    bus.y        = b;
`ifdef MULT_SIGNED_EN
    bus.tc       = t;
`endif
    @(posedge clk);
    #1;
    sbq.push_back('{model(a, b, t), cyc});
    bus.in_valid = 1'b0;
    for (int i = 0; i < garbage; i++) begin
      @(negedge clk);
      check("in_ready_busy", bus.in_ready, 0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.x        = WIDTH'($urandom);
      bus.y        = WIDTH'($urandom);
`ifdef MULT_SIGNED_EN
      bus.tc       = 1'($urandom_range(0, 1));
`endif
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((sbq.size() != 0 || bus.out_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending", sbq.size(), 0);
  endtask

  initial begin
    logic [PW-1:0] exp_p;
    int            w;
    int            lat;
    logic          t;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.x          = '0;
    bus.y          = '0;
    bus.out_ready  = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.x         = '0;
    bus4.y         = '0;
    bus4.out_ready = 1'b1;
`ifdef MULT_SIGNED_EN
    bus.tc         = 1'b0;
    bus4.tc        = 1'b0;
`endif

    // Monitor: compare each new product against the scoreboard head.
    fork
      begin
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
          @(negedge clk);
          if (rst) begin
            seen = 1'b0;
          end else if (bus.out_valid && !seen) begin
            seen = 1'b1;
            if (sbq.size() == 0) begin
              check("unexpected_out_valid", bus.out_valid, 0);
            end else begin
              e = sbq.pop_front();
              check("product", bus.p, e.p);
              check("latency", cyc - e.cyc, N + 1);
            end
          end else if (!bus.out_valid) begin
            seen = 1'b0;
          end
          if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_p", bus.p, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1);

    // Directed products.
    issue(16'd3, 16'd5, 1'b0, N);
    wait_drain();
    issue(16'hFFFF, 16'hFFFF, 1'b0, N);
    wait_drain();
    issue(16'h0000, 16'hABCD, 1'b0, N);
    wait_drain();
`ifdef MULT_SIGNED_EN
    issue(16'hFFFF, 16'h0005, 1'b1, N);
    issue(16'h8000, 16'h8000, 1'b1, N);
    issue(16'h8000, 16'h7FFF, 1'b1, N);
    issue(16'hFFFF, 16'hFFFF, 1'b0, N);
    wait_drain();
`endif

    // Back-pressure: hold the product in DONE for 10 cycles.
    bus.out_ready = 1'b0;
    issue(16'h1234, 16'h5678, 1'b0, N);
    exp_p = model(16'h1234, 16'h5678, 1'b0);
    w = 0;
    while (!bus.out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("stall_reach_done", bus.out_valid, 1);
    repeat (10) begin
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_p", bus.p, exp_p);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("exit_out_valid", bus.out_valid, 0);
    check("exit_in_ready", bus.in_ready, 1);
    check("exit_p_hold", bus.p, exp_p);

    // Random operands with random out_ready and junk inputs while busy.
    rand_ready = 1'b1;
    repeat (40) begin
`ifdef MULT_SIGNED_EN
      t = 1'($urandom_range(0, 1));
`else
      t = 1'b0;
`endif
      issue(WIDTH'($urandom), WIDTH'($urandom), t, N);
    end
    wait_drain();
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;

    // Abort mid-calculation with a one-cycle reset.
    issue(16'h0F0F, 16'h00FF, 1'b0, 6);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready_rst", bus.in_ready, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_p", bus.p, 0);
    sbq.delete();
    rst = 1'b0;
    #1;
    check("abort_in_ready", bus.in_ready, 1);
    issue(16'd2, 16'd3, 1'b0, N);
    wait_drain();
    check("abort_p_fresh", bus.p, 6);

    // STEP=4 instance: latency N+1 = 5 edges.
    @(negedge clk);
    check("s4_in_ready", bus4.in_ready, 1);
    bus4.in_valid = 1'b1;
    bus4.x        = 16'hFFFF;
    bus4.y        = 16'hFFFF;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("s4_latency", lat, 5);
    check("s4_p", bus4.p, 32'hFFFE0001);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
